// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment encoding and pin polarity helpers
package seg7_pkg;

  // All segments off, active-high {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Hex nibble to active-high {a..g}; seg[6]=a, seg[0]=g
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] s;
    case (nibble)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Convert active-high logical bits to pin levels
  function automatic logic [7:0] apply_pol(input logic [7:0] bits, input logic active_low);
    return active_low ? ~bits : bits;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// rtl/seg7_slot_timer.sv - digit slot counter and scan index for the mux driver
module seg7_slot_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx,
  output logic             slot_start,
  output logic             frame_end
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic             slot_last;

  assign slot_last = (cnt == CNT_LAST);

  // cnt wraps every CLK_DIV cycles; idx steps once per wrap and wraps after the last digit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_last) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign slot_start = (cnt == '0);
  assign frame_end  = slot_last && (idx == IDX_LAST);

endmodule

// File: rtl/seg7_mux_driver.sv
// rtl/seg7_mux_driver.sv - time-multiplexed multi-digit 7-segment display driver
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Pin levels for a fully dark display
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = NUM_DIGITS'(apply_pol(8'h00, AN_ACTIVE_LOW));
  localparam logic [7:0]            SEGDP_OFF = apply_pol({SEG_BLANK, 1'b0}, SEG_ACTIVE_LOW);

  logic [IDX_W-1:0]        idx;
  logic                    slot_start;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] snap_value;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    snap_blz;

  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    upper_zero;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    lit;
  logic [6:0]              seg_raw;
  logic                    dp_raw;
  logic [NUM_DIGITS-1:0]   an_raw;
  logic [7:0]              seg_dp_pol;
  logic [NUM_DIGITS-1:0]   an_next;

  seg7_slot_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .CLK_DIV    (CLK_DIV),
    .IDX_W      (IDX_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx        (idx),
    .slot_start (slot_start),
    .frame_end  (frame_end)
  );

  // Capture the inputs once per frame so a frame never mixes old and new digits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_value <= '0;
      snap_dp    <= '0;
      snap_blz   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (frame_end) begin
        snap_value <= value;
        snap_dp    <= dp_in;
        snap_blz   <= blank_lz;
      end
    end
  end

  // Walk from the most significant digit down; a digit blanks while everything above it is zero
  always_comb begin
    blank_mask = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero    = upper_zero && (snap_value[4*i +: 4] == 4'h0);
      blank_mask[i] = snap_blz && (i != 0) && upper_zero && !snap_dp[i];
    end
  end

  // Next pin values: the first cycle of every slot is a dark guard against ghosting
  always_comb begin
    cur_nib = snap_value[{idx, 2'b00} +: 4];
    cur_dp  = snap_dp[idx];
    lit     = enable && !slot_start && !blank_mask[idx];
    seg_raw = SEG_BLANK;
    dp_raw  = 1'b0;
    an_raw  = '0;
    if (lit) begin
      seg_raw = hex_to_seg(cur_nib);
      dp_raw  = cur_dp;
      an_raw  = NUM_DIGITS'(1) << idx;
    end
    seg_dp_pol = apply_pol({seg_raw, dp_raw}, SEG_ACTIVE_LOW);
    an_next    = NUM_DIGITS'(apply_pol(8'(an_raw), AN_ACTIVE_LOW));
  end

  // Register every pin so the board sees glitch-free levels
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEGDP_OFF[7:1];
      dp  <= SEGDP_OFF[0];
    end else begin
      an  <= an_next;
      seg <= seg_dp_pol[7:1];
      dp  <= seg_dp_pol[0];
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb/tb_seg7_mux_driver.sv - scoreboard bench for seg7_mux_driver
module tb_seg7_mux_driver;

  localparam int ND    = 4;
  localparam int CD    = 4;
  localparam int FRAME = ND * CD;

  localparam logic [6:0] DEC_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          enable;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          blank_lz;

  logic [3:0]    an, an_i;
  logic [6:0]    seg, seg_i;
  logic          dp, dp_i;
  logic          frame_tick, frame_tick_i;

  seg7_mux_driver #(
    .NUM_DIGITS(ND), .CLK_DIV(CD), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  seg7_mux_driver #(
    .NUM_DIGITS(ND), .CLK_DIV(CD), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an_i), .seg(seg_i), .dp(dp_i), .frame_tick(frame_tick_i)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] seg_i;
    logic       dp;
    logic       dp_i;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t dark_exp();
    exp_t e;
    e.an    = 4'b1111;
    e.seg   = 7'b0000000;
    e.seg_i = 7'b1111111;
    e.dp    = 1'b0;
    e.dp_i  = 1'b1;
    e.tick  = 1'b0;
    return e;
  endfunction

  // Reference model: position within a 16-cycle frame plus the captured snapshot
  int          pos = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic        m_blz = 1'b0;
  int          cyc = 0;
  int          last_tick = 0;
  bit          tick_seen = 1'b0;

  function automatic bit m_blank(input int d);
    return m_blz && (d != 0) && ((m_val >> (4 * d)) == 16'h0) && !m_dp[d];
  endfunction

  always @(posedge clk) begin : model
    exp_t       e;
    int         d;
    int         c;
    logic [3:0] nib;
    cyc++;
    e = dark_exp();
    if (!rst_n) begin
      pos       = 0;
      m_val     = '0;
      m_dp      = '0;
      m_blz     = 1'b0;
      tick_seen = 1'b0;
    end else begin
      d      = pos / CD;
      c      = pos % CD;
      e.tick = (pos == FRAME - 1);
      if (enable && (c != 0) && !m_blank(d)) begin
        nib     = m_val[4*d +: 4];
        e.an    = ~(4'b0001 << d);
        e.seg   = DEC_TAB[nib];
        e.seg_i = ~DEC_TAB[nib];
        e.dp    = m_dp[d];
        e.dp_i  = ~m_dp[d];
      end
      if (pos == FRAME - 1) begin
        m_val = value;
        m_dp  = dp_in;
        m_blz = blank_lz;
      end
      pos = (pos + 1) % FRAME;
    end
    exp_q.push_back(e);
  end

  // Compare registered outputs half a cycle after each edge
  always @(negedge clk) begin : sampler
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("an", 32'(an), 32'(e.an));
      check_eq("seg", 32'(seg), 32'(e.seg));
      check_eq("dp", 32'(dp), 32'(e.dp));
      check_eq("frame_tick", 32'(frame_tick), 32'(e.tick));
      check_eq("an_inv", 32'(an_i), 32'(e.an));
      check_eq("seg_inv", 32'(seg_i), 32'(e.seg_i));
      check_eq("dp_inv", 32'(dp_i), 32'(e.dp_i));
      check_eq("frame_tick_inv", 32'(frame_tick_i), 32'(e.tick));
      if (frame_tick === 1'b1) begin
        if (tick_seen) check_eq("tick_period", 32'(cyc - last_tick), 32'(FRAME));
        last_tick = cyc;
        tick_seen = 1'b1;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    value    = 16'h0000;
    dp_in    = 4'b0000;
    blank_lz = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2 * FRAME);

    value = 16'h12AF;
    cycles(2 * FRAME);

    value    = 16'h0030;
    blank_lz = 1'b1;
    cycles(2 * FRAME);
    value = 16'h0000;
    cycles(2 * FRAME);

    value    = 16'h1111;
    blank_lz = 1'b0;
    cycles(2 * FRAME);
    cycles(6);
    value = 16'h2222;
    cycles(2 * FRAME - 6);

    value = 16'h8888;
    dp_in = 4'b0100;
    cycles(2 * FRAME);

    cycles(5);
    enable = 1'b0;
    cycles(10);
    enable = 1'b1;
    cycles(2 * FRAME - 15);

    cycles(7);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(2 * FRAME);

    for (int f = 0; f < 12 * FRAME; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        value    = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_in    = 4'($urandom_range(0, 15));
        blank_lz = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      cycles(1);
    end
    rst_n  = 1'b1;
    enable = 1'b1;
    cycles(FRAME);

    #1;
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_mux_driver.md
Name: seg7_mux_driver

Overview:
- Parametrised multi-digit, time-multiplexed 7-segment display driver.
- Successor to the single-digit combinational hex decoder; drives NUM_DIGITS common-anode/cathode digits from one packed hex word.
- Adds scan timing, a frame-coherent snapshot, anti-ghosting guard cycles, decimal points, leading-zero blanking and configurable output polarity.
- Sits between datapath registers and board pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- CLK_DIV, 50000, clock cycles per digit slot (>=2).
- SEG_ACTIVE_LOW, 0, 1 = seg/dp pins driven low to light.
- AN_ACTIVE_LOW, 1, 1 = digit-enable pins driven low to select.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  0 = all digits dark; scan timing keeps running.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i (value[4i+3:4i]) belongs to digit i; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- blank_lz  in  1  1 = blank leading zero digits.
- an  out  NUM_DIGITS  digit enables, one-hot when lit.
- seg  out  7  segments {a,b,c,d,e,f,g}; seg[6]=a, seg[0]=g.
- dp  out  1  decimal point segment.
- frame_tick  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low.
- Reset state:
  - cnt=0, idx=0, snapshot value/dp = 0, frame_tick = 0.
  - an all inactive, seg and dp off, at their polarity-correct levels.
- Slot counter:
  - cnt counts 0..CLK_DIV-1 and wraps.
  - When cnt=CLK_DIV-1, idx advances; it wraps from NUM_DIGITS-1 to 0.
- Snapshot:
  - Loaded from value/dp_in/blank_lz on the cycle where cnt=CLK_DIV-1 and idx=NUM_DIGITS-1.
  - frame_tick is registered high the following cycle, aligned with idx=0, cnt=0.
  - Input changes mid-frame never appear until the next frame (no tearing).
  - The first frame after reset displays the zero snapshot.
- Outputs:
  - All outputs are registered.
  - an, seg and dp in cycle t+1 reflect idx, cnt and snapshot in cycle t (1-cycle latency).
- Guard cycle:
  - Whenever cnt=0, outputs are dark: all an inactive, seg and dp off.
  - The lit portion of each slot is CLK_DIV-1 cycles.
- Lit digit:
  - an[idx] active, all others inactive.
  - seg = decode(snapshot nibble idx); dp = snapshot dp[idx]; polarity applied last.
- Decode table, active-high {a..g}, using the existing team encoding:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Leading-zero blanking (snapshot blank_lz=1):
  - Digit i is blank when nibbles i..NUM_DIGITS-1 are all zero and dp[i]=0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode inactive for the whole slot.
- enable:
  - enable=0 forces dark outputs on the next cycle.
  - cnt, idx, snapshot and frame_tick continue unaffected.
- Reset mid-operation: next cycle all state is back to reset values; no partial frame is resumed.
- NUM_DIGITS=1: idx stays 0; a snapshot is taken every slot.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK constant, 7'b0000000.
  - Function hex_to_seg(nibble) holding the table above; shared with the single-digit decoder.
  - Function apply_pol(bits, active_low).
- Sub-module seg7_slot_timer: cnt/idx counters, emitting slot_start (cnt=0) and frame_end (last cycle of the frame).
- Snapshot, blanking and output registers stay in the top module.

Test Plan (NUM_DIGITS=4, CLK_DIV=4, AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0):
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles.
  - Response: an=1111, seg=0000000, dp=0, frame_tick=0.
  - After release, the first frame shows digit 0 lit with seg=1111110 and digits 1-3 showing 0 with blank_lz=0.
- Scan order:
  - Stimulus: value=16'h12AF, blank_lz=0.
  - Response, next frame: each slot has 1 dark cycle, then 3 lit cycles.
  - an sequence 1110/1101/1011/0111 with seg 1000111/1110111/1101101/0110000.
  - frame_tick pulses once every 16 cycles.
- Blanking:
  - Stimulus: value=16'h0030, blank_lz=1.
  - Response: digits 3 and 2 keep an inactive; digit 1 seg=1111001; digit 0 seg=1111110.
  - Stimulus: value=16'h0000.
  - Response: only digit 0 is lit, seg=1111110.
- Tearing:
  - Stimulus: change value from 16'h1111 to 16'h2222 during digit 1's slot.
  - Response: the rest of that frame shows 0110000; the new value appears only after the next frame_tick.
- Decimal point and polarity:
  - Stimulus: dp_in=4'b0100, with SEG_ACTIVE_LOW=1 in a second instance.
  - Response: dp is active only while an[2] is lit; seg bits are inverted, e.g. 8 appears as 0000000.
- Enable and mid-frame reset:
  - Stimulus: drop enable mid-slot.
  - Response: dark next cycle; frame_tick period unchanged.
  - Stimulus: assert rst_n=0 mid-frame.
  - Response: next cycle idx=0, cnt=0, outputs dark.
